// File: rtl/sram_pkg.sv
// Shared types and helpers for the async-SRAM initiator.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACC_LO,
        GAP_LO,
        ACC_HI,
        GAP_HI
    } state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    typedef logic [15:0] halfword_t;

    // Byte enables belonging to one halfword of a 32-bit word.
    function automatic logic [1:0] half_be(input logic [3:0] be, input logic half);
        return (half == HALF_HI) ? be[3:2] : be[1:0];
    endfunction

    // Write data belonging to one halfword of a 32-bit word.
    function automatic halfword_t half_data(input logic [31:0] data, input logic half);
        return (half == HALF_HI) ? data[31:16] : data[15:0];
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Async-SRAM initiator: turns one 32-bit CPU request into up to two timed
// 16-bit SRAM cycles (low half first) and returns a single response pulse.
// Every SRAM pin comes straight from a flop; the output process computes
// the value each pin takes in the state being entered.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [3:0]         req_be,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [15:0]        sram_data,
    output logic               sram_ce_n,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    state_t             state_q, state_nx;
    logic [3:0]         cnt_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [SRAM_AW-2:0] base_q;
    halfword_t          rbuf_lo, rbuf_hi;
    halfword_t          dout_q, dout_d;
    logic               drive_q, drive_d;
    logic [SRAM_AW-1:0] addr_d;
    logic               ce_d, we_d, oe_d, ub_d, lb_d, resp_d;

    // Byte-address bits outside the halfword address are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:SRAM_AW+1], req_addr[1:0]};

    logic idle;
    assign idle      = (state_q == IDLE);
    assign req_ready = idle;

    // In IDLE the request being accepted is still on the inputs; later it is in the holding registers.
    logic               we_cur;
    logic [3:0]         be_cur;
    logic [31:0]        wdata_cur;
    logic [SRAM_AW-2:0] base_cur;
    assign we_cur    = idle ? req_we    : we_q;
    assign be_cur    = idle ? req_be    : be_q;
    assign wdata_cur = idle ? req_wdata : wdata_q;
    assign base_cur  = idle ? req_addr[SRAM_AW:2] : base_q;

    logic acc_nx, gap_nx, half_nx;
    assign acc_nx  = (state_nx == ACC_LO) || (state_nx == ACC_HI);
    assign gap_nx  = (state_nx == GAP_LO) || (state_nx == GAP_HI);
    assign half_nx = (state_nx == ACC_HI) ? HALF_HI : HALF_LO;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_nx;
    end

    // Next-state logic; a write skips any half whose byte enables are all zero.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_nx unassigned (no latch).
        state_nx = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!req_we || (req_be[1:0] != 2'b00)) state_nx = ACC_LO;
                    else if (req_be[3:2] != 2'b00)         state_nx = ACC_HI;
                    // Empty write: one strobe-free cycle so the response lands one cycle later.
                    else                                   state_nx = GAP_HI;
                end
            end
            ACC_LO:  if (cnt_q == 4'd0) state_nx = GAP_LO;
            GAP_LO:  state_nx = (we_q && (be_q[3:2] == 2'b00)) ? IDLE : ACC_HI;
            ACC_HI:  if (cnt_q == 4'd0) state_nx = GAP_HI;
            GAP_HI:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pin values for the state being entered; registered below so the pins are glitch-free.
    always_comb begin
        addr_d  = sram_addr;
        ce_d    = 1'b1;
        we_d    = 1'b1;
        oe_d    = 1'b1;
        ub_d    = 1'b1;
        lb_d    = 1'b1;
        dout_d  = dout_q;
        drive_d = 1'b0;
        resp_d  = ((state_q == GAP_LO) || (state_q == GAP_HI)) && (state_nx == IDLE);
        if (acc_nx) begin
            addr_d = {base_cur, half_nx};
            ce_d   = 1'b0;
            if (we_cur) begin
                we_d         = 1'b0;
                {ub_d, lb_d} = ~half_be(be_cur, half_nx);
                dout_d       = half_data(wdata_cur, half_nx);
                drive_d      = 1'b1;
            end else begin
                oe_d = 1'b0;
                ub_d = 1'b0;
                lb_d = 1'b0;
            end
        end else if (gap_nx) begin
            // Keep write data on the bus through the gap for hold time.
            drive_d = drive_q;
        end
    end

    // Output registers for every SRAM pin and the response pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sram_addr  <= '0;
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            dout_q     <= '0;
            drive_q    <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            sram_addr  <= addr_d;
            sram_ce_n  <= ce_d;
            sram_we_n  <= we_d;
            sram_oe_n  <= oe_d;
            sram_ub_n  <= ub_d;
            sram_lb_n  <= lb_d;
            dout_q     <= dout_d;
            drive_q    <= drive_d;
            resp_valid <= resp_d;
        end
    end

    assign sram_data = drive_q ? dout_q : {16{1'bz}};

    // Wait counter: loaded on entry to an access state, counts down to the last access cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            cnt_q <= 4'd0;
        else if (acc_nx && state_nx != state_q) cnt_q <= 4'(WAIT_CYCLES);
        else if (cnt_q != 4'd0)                cnt_q <= cnt_q - 4'd1;
    end

    // Hold the accepted request for the duration of the transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= '0;
            base_q  <= '0;
        end else if (idle && req_valid) begin
            we_q    <= req_we;
            be_q    <= req_be;
            wdata_q <= req_wdata;
            base_q  <= req_addr[SRAM_AW:2];
        end
    end

    // Capture read halves in the last access cycle; publish the word as the response goes out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rbuf_lo    <= '0;
            rbuf_hi    <= '0;
            resp_rdata <= '0;
        end else begin
            if (state_q == ACC_LO && cnt_q == 4'd0 && !we_q) rbuf_lo <= sram_data;
            if (state_q == ACC_HI && cnt_q == 4'd0 && !we_q) rbuf_hi <= sram_data;
            if (state_q == GAP_HI && !we_q)                  resp_rdata <= {rbuf_hi, rbuf_lo};
        end
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Initiator side of the external async-SRAM bus: 20-bit halfword address, 16-bit bidirectional data, active-low CE/WE/OE/UB/LB. The `dmem` bench model is the responder on this bus.
- Sits between the CPU load/store unit and the board pins inside `top`.
- Converts one 32-bit word request into up to two timed 16-bit SRAM cycles, low half first, and returns one response.

Parameters:
- WAIT_CYCLES, 1: extra cycles the strobes stay active per halfword access. Active time is WAIT_CYCLES+1 cycles. Legal range 0..15.
- SRAM_AW, 20: SRAM halfword address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address. Bits [1:0] and [31:21] are ignored.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables for writes; ignored for reads.
- resp_valid  out  1  one-cycle completion pulse, for reads and writes.
- resp_rdata  out  32  read data; held until the next read response.
- sram_addr  out  20  halfword address.
- sram_data  inout  16  SRAM data bus.
- sram_ce_n  out  1  chip enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_ub_n  out  1  upper byte select, active low.
- sram_lb_n  out  1  lower byte select, active low.

Behaviour:
- Reset values:
  - req_ready=1, resp_valid=0, resp_rdata=0.
  - sram_addr=0.
  - All sram_*_n=1.
  - sram_data=Z.
  - State=IDLE.
- Every SRAM-side output is driven from a flop, so the pins are glitch-free.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. Requests presented while busy are not accepted and must be held by the CPU.
- Addresses: LO half = {req_addr[20:2],1'b0}, HI half = {req_addr[20:2],1'b1}. LO carries wdata[15:0] with be[1:0]; HI carries wdata[31:16] with be[3:2].
- Half skipping:
  - A write skips any half whose two be bits are both 0.
  - A write with be=0000 does no SRAM access; resp_valid is asserted the cycle after acceptance.
  - Reads always access both halves.
- States: IDLE -> ACC_LO -> GAP_LO -> ACC_HI -> GAP_HI -> IDLE. Skipped halves bypass their ACC and GAP states.
- ACC_x (WAIT_CYCLES+1 cycles, counted by an internal down-counter):
  - sram_addr set to the half address; sram_ce_n=0.
  - Read: sram_oe_n=0, ub_n=lb_n=0.
  - Write: sram_we_n=0, ub_n=!be[hi], lb_n=!be[lo], sram_data driven with that half's write data.
- Read sampling: sram_data is captured into the matching half of the read-data register in the last ACC cycle.
- GAP_x (1 cycle):
  - All strobes high.
  - sram_addr held.
  - For writes, sram_data stays driven to give data hold; it is released (Z) on exit from GAP.
- Response:
  - resp_valid pulses for one cycle on the IDLE cycle that follows the final GAP. req_ready is also 1 in that cycle, so back-to-back requests are allowed.
  - resp_rdata updates only on reads.
- Latency from acceptance edge to resp_valid:
  - Full word: 2*(WAIT_CYCLES+2) cycles.
  - Single half: WAIT_CYCLES+2 cycles.
- sram_data is never driven while sram_oe_n=0. OE and WE are never low together.
- sram_addr holds its last value in IDLE.
- Reset mid-operation: the FSM returns to IDLE, strobes go high and the bus goes Z asynchronously. No resp_valid is produced for the aborted request. The next request after release executes normally.

Decomposition:
- sram_pkg holds:
  - state_t enum {IDLE, ACC_LO, GAP_LO, ACC_HI, GAP_HI}.
  - Localparams HALF_LO=1'b0, HALF_HI=1'b1.
  - Typedef halfword_t (logic [15:0]).
- No sub-module; the wait counter and FSM are kept inline.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-bus, then release. Required: all sram_*_n=1, sram_data=Z, req_ready=1, resp_valid=0.
- Full-word write (WAIT_CYCLES=1): write 0xDEADBEEF to addr 0x00000010, be=1111, into dmem. Required: addr 0x00008 with WE_n=0 and data 0xBEEF for 2 cycles, a 1-cycle gap, then 0x00009 with 0xDEAD; resp_valid 6 cycles after acceptance.
- Full-word read: read addr 0x00000010. Required: OE_n=0 and WE_n=1 throughout, bus never driven by the controller, resp_rdata=0xDEADBEEF, latency 6.
- Byte write: write data 0x00AA0000 with be=0100. Required: only the HI access occurs, with UB_n=1, LB_n=0, data 0x00AA, latency 3. A following read returns 0xDEAABEEF.
- Stall and empty write: req_valid held during a busy read is not accepted until IDLE. A write with be=0000 produces no strobes and resp_valid 1 cycle later.
- Slow SRAM and mid-access reset: with WAIT_CYCLES=3, a full read has latency 10. Asserting reset during ACC_HI deasserts strobes immediately with no resp_valid; the next write/read pair completes correctly.
